neuron_activate: RTL and testbench

Multi-channel bias-add, rescale and activation stage that follows the MAC accumulators in each SNN/ANN layer. It generalises the single-neuron bias+ReLU stage to CHANNELS parallel neurons, selectable activation modes, fixed-point rescaling and saturation to a narrower output width. A two-stage valid/ready pipeline lets it stall cleanly against the next layer.

---
 rtl/neuron_pkg.sv | 25 ++
 rtl/neuron_activate_lane.sv | 41 ++++
 rtl/neuron_activate.sv | 125 ++++++++++++
 tb/tb_neuron_activate.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// Shared types and helpers for the neuron activation and pooling stages.
package neuron_pkg;

  typedef enum logic [1:0] {
    ACT_NONE  = 2'd0,
    ACT_RELU  = 2'd1,
    ACT_LEAKY = 2'd2,
    ACT_BRELU = 2'd3
  } act_mode_e;

  localparam int unsigned SAT_TOTAL_W = 16;

  // Clip a signed value to the range of a signed integer of the given width.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                  input int unsigned bits);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (bits - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (bits - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/neuron_activate_lane.sv
// One channel's stage-2 datapath: activation select, CAP bound, clip and saturation flag.
module neuron_activate_lane
  import neuron_pkg::*;
#(
  parameter int unsigned S_BITS     = 33,
  parameter int unsigned OUT_BITS   = 16,
  parameter int unsigned LEAK_SHIFT = 3,
  parameter int          CAP        = 32767
) (
  input  logic [1:0]          mode,
  input  logic [S_BITS-1:0]   scaled,
  output logic [OUT_BITS-1:0] act_out,
  output logic                sat
);

  localparam logic signed [S_BITS-1:0] CAP_S  = S_BITS'(CAP);
  localparam logic signed [S_BITS-1:0] ZERO_S = '0;

  logic signed [S_BITS-1:0] s;
  logic signed [S_BITS-1:0] act;
  logic signed [63:0]       act_w;
  logic signed [63:0]       clip_w;

  always_comb begin
    s   = $signed(scaled);
    act = s;
    case (act_mode_e'(mode))
      ACT_NONE:  act = s;
      ACT_RELU:  act = (s > ZERO_S) ? s : ZERO_S;
      ACT_LEAKY: act = (s > ZERO_S) ? s : (s >>> LEAK_SHIFT);
      ACT_BRELU: act = (s <= ZERO_S) ? ZERO_S : ((s > CAP_S) ? CAP_S : s);
      default:   act = s;
    endcase
    // Only the final range clip counts as saturation; CAP and zeroing do not.
    act_w   = 64'(act);
    clip_w  = saturate(act_w, OUT_BITS);
    act_out = clip_w[OUT_BITS-1:0];
    sat     = (clip_w != act_w);
  end

endmodule

// File: rtl/neuron_activate.sv
// Multi-channel bias-add, rescale and activation stage with a two-deep valid/ready pipeline.
module neuron_activate
  import neuron_pkg::*;
#(
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned IN_BITS    = 32,
  parameter int unsigned B_BITS     = 16,
  parameter int unsigned OUT_BITS   = 16,
  parameter int unsigned FRAC_SHIFT = 8,
  parameter int unsigned LEAK_SHIFT = 3,
  parameter int          CAP        = (2 ** (OUT_BITS - 1)) - 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [1:0]                   mode,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CHANNELS*IN_BITS-1:0]  in_data,
  input  logic [CHANNELS*B_BITS-1:0]   bias,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CHANNELS*OUT_BITS-1:0] out_data,
  output logic [CHANNELS-1:0]          out_sat,
  output logic [SAT_TOTAL_W-1:0]       sat_total
);

  localparam int unsigned S_BITS = IN_BITS + 1;
  localparam int unsigned ST_W1  = SAT_TOTAL_W + 1;

  logic                         s1_valid_q,  s1_valid_d;
  logic [CHANNELS*S_BITS-1:0]   s1_scaled_q, s1_scaled_d;
  act_mode_e                    s1_mode_q,   s1_mode_d;
  logic                         out_valid_q, out_valid_d;
  logic [CHANNELS*OUT_BITS-1:0] out_data_q,  out_data_d;
  logic [CHANNELS-1:0]          out_sat_q,   out_sat_d;
  logic [SAT_TOTAL_W-1:0]       sat_total_q, sat_total_d;

  logic [CHANNELS*S_BITS-1:0]   scaled_in;
  logic [CHANNELS*OUT_BITS-1:0] lane_act;
  logic [CHANNELS-1:0]          lane_sat;
  logic [ST_W1-1:0]             sat_sum;
  logic                         s2_adv;
  logic                         s1_adv;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic signed [S_BITS-1:0] sum;
    // One extra bit holds the sum of two sign-extended operands without overflow.
    assign sum = S_BITS'($signed(in_data[c*IN_BITS +: IN_BITS]))
               + S_BITS'($signed(bias[c*B_BITS +: B_BITS]));
    assign scaled_in[c*S_BITS +: S_BITS] = sum >>> FRAC_SHIFT;

    neuron_activate_lane #(
      .S_BITS     (S_BITS),
      .OUT_BITS   (OUT_BITS),
      .LEAK_SHIFT (LEAK_SHIFT),
      .CAP        (CAP)
    ) u_lane (
      .mode    (s1_mode_q),
      .scaled  (s1_scaled_q[c*S_BITS +: S_BITS]),
      .act_out (lane_act[c*OUT_BITS +: OUT_BITS]),
      .sat     (lane_sat[c])
    );
  end

  assign s2_adv   = !out_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;
  assign sat_sum  = {1'b0, sat_total_q} + ST_W1'($countones(out_sat_q));

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_scaled_d = s1_scaled_q;
    s1_mode_d   = s1_mode_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    sat_total_d = sat_total_q;

    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_scaled_d = scaled_in;
        s1_mode_d   = act_mode_e'(mode);
      end
    end

    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d = lane_act;
        out_sat_d  = lane_sat;
      end
    end

    if (out_valid_q && out_ready) begin
      sat_total_d = sat_sum[SAT_TOTAL_W] ? '1 : sat_sum[SAT_TOTAL_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_scaled_q <= '0;
      s1_mode_q   <= ACT_NONE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= '0;
      sat_total_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_scaled_q <= s1_scaled_d;
      s1_mode_q   <= s1_mode_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      sat_total_q <= sat_total_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign sat_total = sat_total_q;

endmodule

// File: tb/tb_neuron_activate.sv
// Self-checking bench for neuron_activate: vector table plus scoreboarded stream sequences.
module tb_neuron_activate;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic        in_valid;
  logic        in_ready;
  logic [127:0] in_data;
  logic [63:0] bias;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [3:0]  out_sat;
  logic [15:0] sat_total;

  always #5 clk = ~clk;

  neuron_activate #(
    .CHANNELS   (4),
    .IN_BITS    (32),
    .B_BITS     (16),
    .OUT_BITS   (16),
    .FRAC_SHIFT (8),
    .LEAK_SHIFT (3),
    .CAP        (6)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .bias      (bias),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .sat_total (sat_total)
  );

  typedef struct {
    logic [63:0] data;
    logic [3:0]  sat;
  } exp_t;

  typedef struct {
    logic [31:0] d;
    logic [15:0] b;
    logic [1:0]  m;
    logic [15:0] o;
    logic        s;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   pops   = 0;
  int   ncyc   = 0;
  exp_t sb[$];
  logic [15:0] exp_sat_total = '0;
  bit   tbl_active = 1'b0;
  exp_t tbl_exp;
  vec_t tbl[15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void model(input logic [31:0] d, input logic [15:0] b, input logic [1:0] m,
                                output logic [15:0] o, output logic s);
    longint sum, sc, act, cl;
    sum = longint'($signed(d)) + longint'($signed(b));
    sc  = sum >>> 8;
    case (m)
      2'd0:    act = sc;
      2'd1:    act = (sc > 0) ? sc : 0;
      2'd2:    act = (sc > 0) ? sc : (sc >>> 3);
      default: act = (sc <= 0) ? 0 : ((sc > 6) ? 6 : sc);
    endcase
    cl = (act > 32767) ? 32767 : ((act < -32768) ? -32768 : act);
    s  = (cl != act);
    o  = cl[15:0];
  endfunction

  task automatic cycle(output bit acc);
    exp_t e;
    logic [15:0] o;
    logic s;
    int unsigned t;
    acc = 1'b0;
    #1;
    if (rst) begin
      sb.delete();
      exp_sat_total = '0;
    end else begin
      if (in_valid && in_ready) begin
        acc = 1'b1;
        if (tbl_active) e = tbl_exp;
        else begin
          for (int c = 0; c < 4; c++) begin
            model(in_data[c*32 +: 32], bias[c*16 +: 16], mode, o, s);
            e.data[c*16 +: 16] = o;
            e.sat[c] = s;
          end
        end
        sb.push_back(e);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) check("output_without_beat", 64'(sb.size()), 64'd1);
        else begin
          e = sb.pop_front();
          check("out_data", out_data, e.data);
          check("out_sat", {60'd0, out_sat}, {60'd0, e.sat});
          pops++;
          t = exp_sat_total + $countones(e.sat);
          exp_sat_total = (t > 65535) ? 16'hFFFF : t[15:0];
        end
      end
    end
    @(posedge clk);
    #1;
    ncyc++;
  endtask

  task automatic step();
    bit acc;
    cycle(acc);
  endtask

  task automatic send();
    bit acc;
    int i;
    in_valid = 1'b1;
    acc = 1'b0;
    for (i = 0; i < 50 && !acc; i++) cycle(acc);
    if (!acc) check("accept_timeout", 64'(acc), 64'd1);
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int i = 0; i < 30 && sb.size() > 0; i++) step();
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  task automatic rand_beat(input int i);
    logic [31:0] d;
    for (int c = 0; c < 4; c++) begin
      d = $urandom;
      if ((i + c) % 2 == 0) d = {{12{d[19]}}, d[19:0]};
      in_data[c*32 +: 32] = d;
      bias[c*16 +: 16]    = 16'($urandom);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int start, p0, nacc;
    bit acc;

    tbl[0]  = '{32'h00000A00, 16'h0100, 2'd1, 16'd11,    1'b0};
    tbl[1]  = '{32'hFFFFF000, 16'h0000, 2'd1, 16'h0000,  1'b0};
    tbl[2]  = '{32'hFFFFF000, 16'h0000, 2'd0, 16'hFFF0,  1'b0};
    tbl[3]  = '{32'hFFFFF000, 16'h0000, 2'd2, 16'hFFFE,  1'b0};
    tbl[4]  = '{32'h00000900, 16'h0000, 2'd3, 16'd6,     1'b0};
    tbl[5]  = '{32'h7FFFFF00, 16'h0000, 2'd0, 16'h7FFF,  1'b1};
    tbl[6]  = '{32'h80000000, 16'h8000, 2'd0, 16'h8000,  1'b1};
    tbl[7]  = '{32'hFFFFFFFF, 16'h0000, 2'd2, 16'hFFFF,  1'b0};
    tbl[8]  = '{32'h7FFFFF00, 16'h0000, 2'd1, 16'h7FFF,  1'b1};
    tbl[9]  = '{32'h7FFFFF00, 16'h0000, 2'd3, 16'd6,     1'b0};
    tbl[10] = '{32'h80000000, 16'h0000, 2'd2, 16'h8000,  1'b1};
    tbl[11] = '{32'h00007FFF, 16'h7FFF, 2'd0, 16'h00FF,  1'b0};
    tbl[12] = '{32'hFFFFFF00, 16'hFFFF, 2'd0, 16'hFFFE,  1'b0};
    tbl[13] = '{32'h00000000, 16'h0000, 2'd1, 16'h0000,  1'b0};
    tbl[14] = '{32'h00000100, 16'h0000, 2'd3, 16'd1,     1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; mode = 2'd0; in_data = '0; bias = '0;
    step(); step();
    rst = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_out_sat", 64'(out_sat), 64'd0);
    check("rst_sat_total", 64'(sat_total), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // Table vectors on channel 0; other channels carry zeros and must produce 0.
    tbl_active = 1'b1;
    out_ready  = 1'b1;
    for (int i = 0; i < 15; i++) begin
      in_data = {96'd0, tbl[i].d};
      bias    = {48'd0, tbl[i].b};
      mode    = tbl[i].m;
      tbl_exp.data = {48'd0, tbl[i].o};
      tbl_exp.sat  = {3'b000, tbl[i].s};
      send();
    end
    drain();
    tbl_active = 1'b0;
    check("sat_total_after_table", 64'(sat_total), 64'd4);

    // Stall: two beats in, then backpressure with a third beat waiting.
    mode = 2'd1;
    rand_beat(0); send();
    rand_beat(1); send();
    out_ready = 1'b0;
    rand_beat(2);
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle(acc);
      check("stall_no_accept", 64'(acc), 64'd0);
      check("stall_in_ready", 64'(in_ready), 64'd0);
      check("stall_out_valid", 64'(out_valid), 64'd1);
      check("stall_out_data", out_data, sb[0].data);
    end
    out_ready = 1'b1;
    p0 = pops - 0;
    p0 = pops;
    start = ncyc;
    send();
    for (int i = 3; i < 8; i++) begin
      rand_beat(i);
      send();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 40 && (pops - p0) < 8; i++) step();
    check("stream_pops", 64'(pops - p0), 64'd8);
    check("stream_cycles", 64'(ncyc - start), 64'd8);
    check("stream_queue_empty", 64'(sb.size()), 64'd0);

    // Mode changes every beat over a back-to-back stream.
    for (int i = 0; i < 12; i++) begin
      mode = 2'(i % 4);
      rand_beat(i);
      send();
    end
    drain();
    check("sat_total_model", 64'(sat_total), 64'(exp_sat_total));

    // Reset with two beats in flight.
    mode = 2'd0;
    rand_beat(5); send();
    rand_beat(6); send();
    in_valid = 1'b0; out_ready = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_sat_total", 64'(sat_total), 64'd0);
    check("midrst_out_data", out_data, 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    check("midrst_no_output", 64'(out_valid), 64'd0);

    // Drive sat_total to 0xFFFE, then past the top.
    mode    = 2'd0;
    in_data = {4{32'h7FFFFF00}};
    bias    = '0;
    in_valid = 1'b1;
    nacc = 0;
    for (int i = 0; i < 20000 && nacc < 16383; i++) begin
      cycle(acc);
      nacc += int'(acc);
    end
    check("preload_accepts", 64'(nacc), 64'd16383);
    in_data = {64'd0, {2{32'h7FFFFF00}}};
    send();
    drain();
    check("sat_total_fffe", 64'(sat_total), 64'hFFFE);
    in_data = {4{32'h7FFFFF00}};
    send();
    drain();
    check("sat_total_ffff", 64'(sat_total), 64'hFFFF);
    send();
    drain();
    check("sat_total_sticky", 64'(sat_total), 64'hFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
